// File: rtl/tx_record_scheduler_if.sv
// ============================================================================
//  Module      : tx_record_scheduler_if
//  Description : Bundles the three buses of the transmit record scheduler:
//                the writer port (RAM searcher), the single-port RAM and the
//                packet-builder record stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tx_record_scheduler_if #(
   parameter int ADDR_W        = 9,
   parameter int WORDS_PER_REC = 8
);
   localparam int c_WORD_W = $clog2(WORDS_PER_REC);

   // Writer (RAM searcher) port
   logic                wr_req;
   logic [ADDR_W-1:0]   wr_addr;
   logic [31:0]         wr_data;
   logic                wr_gnt;

   // Shared single-port RAM
   logic [ADDR_W-1:0]   ram_addr;
   logic [31:0]         ram_wdata;
   logic                ram_wren;
   logic [31:0]         ram_rdata;

   // Packet-builder record stream
   logic                pb_ready;
   logic                pb_done;
   logic                rec_valid;
   logic [31:0]         rec_data;
   logic [c_WORD_W-1:0] rec_word;
   logic                rec_last;

   // Scheduler side
   modport master (
      input  wr_req, wr_addr, wr_data, ram_rdata, pb_ready, pb_done,
      output wr_gnt, ram_addr, ram_wdata, ram_wren,
             rec_valid, rec_data, rec_word, rec_last
   );

   // Environment side (writer, RAM and packet builder)
   modport slave (
      output wr_req, wr_addr, wr_data, ram_rdata, pb_ready, pb_done,
      input  wr_gnt, ram_addr, ram_wdata, ram_wren,
             rec_valid, rec_data, rec_word, rec_last
   );
endinterface

`default_nettype wire

// File: rtl/tx_record_scheduler.sv
// ============================================================================
//  Module      : tx_record_scheduler
//  Description : Round-robin scan of connection records in the shared RAM.
//                Valid records (word 0 bit 0) are streamed to the packet
//                builder as one atomic burst; the writer owns the RAM port
//                whenever no burst is locked. WORDS_PER_REC must be >= 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_record_scheduler #(
   parameter int NUM_RECORDS   = 32,
   parameter int WORDS_PER_REC = 8,
   parameter int ADDR_W        = 9
) (
   input  wire logic                           clk,
   input  wire logic                           reset,
   input  wire logic                           enable,
   tx_record_scheduler_if.master               bus,
   output logic [$clog2(NUM_RECORDS)-1:0]      cur_rec,
   output logic                                scan_wrap,
   output logic                                busy
);
   localparam int c_REC_W  = $clog2(NUM_RECORDS);
   localparam int c_WORD_W = $clog2(WORDS_PER_REC);
   localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(WORDS_PER_REC - 1);

   localparam logic [2:0] c_IDLE      = 3'd0;
   localparam logic [2:0] c_READ_HDR  = 3'd1;
   localparam logic [2:0] c_CHECK     = 3'd2;
   localparam logic [2:0] c_STREAM    = 3'd3;
   localparam logic [2:0] c_DRAIN     = 3'd4;
   localparam logic [2:0] c_WAIT_DONE = 3'd5;
   localparam logic [2:0] c_NEXT      = 3'd6;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [c_WORD_W-1:0] r_idx;          // word offset issued during STREAM
   logic [c_REC_W-1:0]  r_cur_rec;
   logic                r_scan_wrap;
   logic [ADDR_W-1:0]   r_addr_hold;    // last address driven to the RAM
   logic                r_rec_valid;
   logic [31:0]         r_rec_data;
   logic [c_WORD_W-1:0] r_rec_word;
   logic                r_rec_last;

   logic                w_locked;
   logic                w_gnt;
   logic                w_rd_issue;
   logic [c_WORD_W-1:0] w_rd_off;
   logic [ADDR_W-1:0]   w_base;
   logic [ADDR_W-1:0]   w_ram_addr;

   assign w_base   = ADDR_W'(r_cur_rec) << c_WORD_W;
   assign w_locked = (r_state == c_CHECK) || (r_state == c_STREAM) || (r_state == c_DRAIN);
   // Reset term keeps the grant low while reset is held, even in IDLE
   assign w_gnt    = reset && bus.wr_req && !w_locked;

   // Next-state decode of the scan / burst sequencer
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:      if (enable && bus.pb_ready) w_next_state = c_READ_HDR;
         c_READ_HDR:  if (!bus.wr_req)            w_next_state = c_CHECK;
         c_CHECK: begin
            if (!bus.ram_rdata[0])      w_next_state = c_NEXT;
            else if (WORDS_PER_REC > 2) w_next_state = c_STREAM;
            else                        w_next_state = c_DRAIN;
         end
         c_STREAM:    if (r_idx == c_LAST_WORD)   w_next_state = c_DRAIN;
         c_DRAIN:                                 w_next_state = c_WAIT_DONE;
         c_WAIT_DONE: if (bus.pb_done)            w_next_state = c_NEXT;
         c_NEXT:                                  w_next_state = c_IDLE;
         default:                                 w_next_state = c_IDLE;
      endcase
   end

   // RAM read issue: header in READ_HDR (unless the writer holds the port),
   // word 1 speculatively in CHECK, remaining words in STREAM
   always_comb begin
      w_rd_issue = 1'b0;
      w_rd_off   = '0;
      case (r_state)
         c_READ_HDR: w_rd_issue = !bus.wr_req;
         c_CHECK: begin
            w_rd_issue = 1'b1;
            w_rd_off   = c_WORD_W'(1);
         end
         c_STREAM: begin
            w_rd_issue = 1'b1;
            w_rd_off   = r_idx;
         end
         default: ;
      endcase
   end

   // RAM port mux: writer, then scheduler read, otherwise hold the address
   always_comb begin
      if (w_gnt)           w_ram_addr = bus.wr_addr;
      else if (w_rd_issue) w_ram_addr = w_base + ADDR_W'(w_rd_off);
      else                 w_ram_addr = r_addr_hold;
   end

   assign bus.ram_addr  = w_ram_addr;
   assign bus.ram_wren  = w_gnt;
   assign bus.ram_wdata = w_gnt ? bus.wr_data : 32'h0;
   assign bus.wr_gnt    = w_gnt;

   // Sequencer state, word counter, record pointer and address hold
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= c_IDLE;
         r_idx       <= '0;
         r_cur_rec   <= '0;
         r_scan_wrap <= 1'b0;
         r_addr_hold <= '0;
      end else begin
         r_state     <= w_next_state;
         r_addr_hold <= w_ram_addr;
         r_scan_wrap <= 1'b0;
         if (r_state == c_CHECK)  r_idx <= c_WORD_W'(2);
         if (r_state == c_STREAM) r_idx <= r_idx + c_WORD_W'(1);
         if (r_state == c_NEXT) begin
            r_cur_rec   <= r_cur_rec + c_REC_W'(1);
            r_scan_wrap <= (r_cur_rec == '1);
         end
      end
   end

   // Record stream: capture the word returned one cycle after its address
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rec_valid <= 1'b0;
         r_rec_data  <= '0;
         r_rec_word  <= '0;
         r_rec_last  <= 1'b0;
      end else begin
         r_rec_valid <= 1'b0;
         r_rec_last  <= 1'b0;
         case (r_state)
            c_CHECK: begin
               if (bus.ram_rdata[0]) begin
                  r_rec_valid <= 1'b1;
                  r_rec_data  <= bus.ram_rdata;
                  r_rec_word  <= '0;
               end
            end
            c_STREAM: begin
               r_rec_valid <= 1'b1;
               r_rec_data  <= bus.ram_rdata;
               r_rec_word  <= r_idx - c_WORD_W'(1);
            end
            c_DRAIN: begin
               r_rec_valid <= 1'b1;
               r_rec_data  <= bus.ram_rdata;
               r_rec_word  <= c_LAST_WORD;
               r_rec_last  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.rec_valid = r_rec_valid;
   assign bus.rec_data  = r_rec_data;
   assign bus.rec_word  = r_rec_word;
   assign bus.rec_last  = r_rec_last;
   assign cur_rec       = r_cur_rec;
   assign scan_wrap     = r_scan_wrap;
   assign busy          = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tx_record_scheduler.sv
// ============================================================================
//  Module      : tb_tx_record_scheduler
//  Description : Directed self-checking bench for tx_record_scheduler with a
//                behavioural single-port RAM (1-cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tx_record_scheduler;
   logic       clk;
   logic       reset;
   logic       enable;
   logic [4:0] cur_rec;
   logic       scan_wrap;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:511];

   tx_record_scheduler_if #(.ADDR_W(9), .WORDS_PER_REC(8)) bus ();

   tx_record_scheduler #(
      .NUM_RECORDS   (32),
      .WORDS_PER_REC (8),
      .ADDR_W        (9)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .bus       (bus),
      .cur_rec   (cur_rec),
      .scan_wrap (scan_wrap),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: registered read, write on ram_wren
   always @(posedge clk) begin
      if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rec0_word(input int k);
      return (k == 0) ? 32'h1 : 32'(32'h11111111 * k);
   endfunction

   function automatic logic [31:0] rec2_word(input int k);
      return (k == 0) ? 32'hDEADBEEF : 32'(32'hA0000000 + k);
   endfunction

   function automatic logic [31:0] rec3_word(input int k);
      return (k == 0) ? 32'h3 : 32'(32'hB0000000 + k);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      for (int k = 0; k < 8; k++) mem[k] = rec0_word(k);
      bus.ram_rdata = 32'h0;

      // ---------------- Reset held during activity ----------------
      reset       = 1'b0;
      enable      = 1'b1;
      bus.pb_ready = 1'b1;
      bus.pb_done = 1'b0;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 9'h055;
      bus.wr_data = 32'hFFFF_FFFF;
      repeat (3) tick();
      check_val("rst_wr_gnt",    bus.wr_gnt,    0);
      check_val("rst_ram_wren",  bus.ram_wren,  0);
      check_val("rst_ram_addr",  bus.ram_addr,  0);
      check_val("rst_ram_wdata", bus.ram_wdata, 0);
      check_val("rst_busy",      busy,          0);
      check_val("rst_cur_rec",   cur_rec,       0);
      check_val("rst_rec_valid", bus.rec_valid, 0);
      check_val("rst_scan_wrap", scan_wrap,     0);

      bus.wr_req = 1'b0;
      enable     = 1'b0;
      reset      = 1'b1;
      repeat (4) tick();
      check_val("idle_busy",     busy,         0);
      check_val("idle_ram_addr", bus.ram_addr, 0);

      // ---------------- Valid record 0 burst ----------------
      enable = 1'b1;
      tick();   // t0
      for (int t = 0; t <= 13; t++) begin
         bus.pb_done = (t == 12);
         #1;
         if (t <= 7) check_val($sformatf("r0_addr_t%0d", t), bus.ram_addr, t);
         if (t == 8) check_val("r0_addr_t8", bus.ram_addr, 7);
         check_val($sformatf("r0_wren_t%0d", t), bus.ram_wren, 0);
         if (t >= 2 && t <= 9) begin
            check_val($sformatf("r0_valid_t%0d", t), bus.rec_valid, 1);
            check_val($sformatf("r0_data_t%0d", t),  bus.rec_data,  rec0_word(t - 2));
            check_val($sformatf("r0_word_t%0d", t),  bus.rec_word,  t - 2);
         end else begin
            check_val($sformatf("r0_valid_t%0d", t), bus.rec_valid, 0);
         end
         check_val($sformatf("r0_last_t%0d", t), bus.rec_last, (t == 9));
         check_val($sformatf("r0_busy_t%0d", t), busy, 1);
         tick();
      end
      bus.pb_done = 1'b0;
      check_val("r0_done_cur_rec", cur_rec, 1);
      check_val("r0_done_busy",    busy,    0);

      // ---------------- All records invalid: full scan ----------------
      mem[0] = 32'h0;
      for (int c = 0; c < 256; c++) begin
         check_val($sformatf("scan_valid_c%0d", c), bus.rec_valid, 0);
         check_val($sformatf("scan_wrap_c%0d", c), scan_wrap, (c == 124 || c == 252));
         if (c % 4 == 0) begin
            check_val($sformatf("scan_cur_rec_c%0d", c), cur_rec, (1 + c / 4) % 32);
            check_val($sformatf("scan_busy_c%0d", c), busy, 0);
         end
         tick();
      end
      enable = 1'b0;
      tick();
      check_val("scan_end_busy",    busy,    0);
      check_val("scan_end_cur_rec", cur_rec, 1);

      // ---------------- Writer contention in READ_HDR ----------------
      enable = 1'b1;
      tick();   // READ_HDR of record 1, base 8
      check_val("wr1_hdr_addr", bus.ram_addr, 9'h008);
      check_val("wr1_hdr_gnt0", bus.wr_gnt,   0);
      bus.wr_req  = 1'b1;
      bus.wr_addr = 9'h010;
      bus.wr_data = 32'hDEADBEEF;
      enable      = 1'b0;
      #1;
      check_val("wr1_gnt",   bus.wr_gnt,    1);
      check_val("wr1_wren",  bus.ram_wren,  1);
      check_val("wr1_addr",  bus.ram_addr,  9'h010);
      check_val("wr1_wdata", bus.ram_wdata, 32'hDEADBEEF);
      tick();
      bus.wr_req = 1'b0;
      #1;
      check_val("wr1_rehdr_addr", bus.ram_addr, 9'h008);
      check_val("wr1_rehdr_gnt",  bus.wr_gnt,   0);
      check_val("wr1_rehdr_busy", busy,         1);
      check_val("wr1_mem",        mem[16],      32'hDEADBEEF);
      tick();   // CHECK
      check_val("wr1_check_addr", bus.ram_addr, 9'h009);
      tick();   // NEXT
      tick();   // IDLE
      check_val("wr1_end_cur_rec", cur_rec, 2);
      check_val("wr1_end_busy",    busy,    0);

      // ---------------- Writer contention during a burst ----------------
      for (int k = 1; k < 8; k++) mem[16 + k] = rec2_word(k);
      enable = 1'b1;
      tick();   // t0, record 2, base 16
      enable = 1'b0;
      for (int t = 0; t <= 12; t++) begin
         if (t == 3) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = 9'h040;
            bus.wr_data = 32'h12345678;
         end
         if (t == 10) bus.wr_req = 1'b0;
         bus.pb_done = (t == 10);
         #1;
         if (t <= 7) check_val($sformatf("wr2_addr_t%0d", t), bus.ram_addr, 16 + t);
         if (t >= 3 && t <= 8) begin
            check_val($sformatf("wr2_gnt_t%0d", t),  bus.wr_gnt,   0);
            check_val($sformatf("wr2_wren_t%0d", t), bus.ram_wren, 0);
         end
         if (t == 9) begin
            check_val("wr2_gnt_t9",   bus.wr_gnt,    1);
            check_val("wr2_addr_t9",  bus.ram_addr,  9'h040);
            check_val("wr2_wdata_t9", bus.ram_wdata, 32'h12345678);
         end
         if (t >= 2 && t <= 9) begin
            check_val($sformatf("wr2_valid_t%0d", t), bus.rec_valid, 1);
            check_val($sformatf("wr2_data_t%0d", t),  bus.rec_data,  rec2_word(t - 2));
            check_val($sformatf("wr2_word_t%0d", t),  bus.rec_word,  t - 2);
            check_val($sformatf("wr2_last_t%0d", t),  bus.rec_last,  (t == 9));
         end
         if (t == 12) begin
            check_val("wr2_end_busy",    busy,    0);
            check_val("wr2_end_cur_rec", cur_rec, 3);
         end
         if (t < 12) tick();
      end
      bus.pb_done = 1'b0;

      // ---------------- Async reset mid-burst ----------------
      for (int k = 0; k < 8; k++) mem[24 + k] = rec3_word(k);
      enable = 1'b1;
      tick();   // t0, record 3, base 24
      check_val("ar_t0_addr", bus.ram_addr, 9'h018);
      repeat (5) tick();   // t5
      check_val("ar_t5_valid", bus.rec_valid, 1);
      check_val("ar_t5_word",  bus.rec_word,  3);
      check_val("ar_t5_data",  bus.rec_data,  rec3_word(3));
      #2;
      reset = 1'b0;
      #1;
      check_val("ar_valid",    bus.rec_valid, 0);
      check_val("ar_last",     bus.rec_last,  0);
      check_val("ar_data",     bus.rec_data,  0);
      check_val("ar_busy",     busy,          0);
      check_val("ar_cur_rec",  cur_rec,       0);
      check_val("ar_ram_addr", bus.ram_addr,  0);
      tick();
      reset = 1'b1;
      check_val("ar_rel_busy", busy, 0);
      tick();   // READ_HDR of record 0
      check_val("ar_rescan_addr",    bus.ram_addr, 0);
      check_val("ar_rescan_busy",    busy,         1);
      check_val("ar_rescan_cur_rec", cur_rec,      0);
      enable = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/tx_record_scheduler.md
Name: tx_record_scheduler

Overview:
- Sequences transmit-side access to the shared single-port connection RAM; sits between the RAM, the RAM searcher (writer) and the packet builder (reader).
- Scans connection records round-robin and reads word 0 of each record. If its valid bit is set, it streams all record words to the packet builder as one atomic burst.
- Arbitrates the single RAM port: the writer has priority except while a burst is locked.

Parameters:
NUM_RECORDS, 32, number of connection records; power of two.
WORDS_PER_REC, 8, 32-bit words per record; power of two.
ADDR_W, 9, RAM address width; must satisfy NUM_RECORDS*WORDS_PER_REC <= 2^ADDR_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  scanning permitted
wr_req  in  1  RAM searcher requests a write
wr_addr  in  ADDR_W  write address
wr_data  in  32  write data
wr_gnt  out  1  combinational grant to the writer
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_wren  out  1  RAM write enable
ram_rdata  in  32  RAM read data; 1-cycle read latency
pb_ready  in  1  packet builder can accept a record
pb_done  in  1  packet builder finished the current record (1-cycle pulse)
rec_valid  out  1  registered; rec_data is valid this cycle
rec_data  out  32  registered record word
rec_word  out  clog2(WORDS_PER_REC)  index of the word on rec_data
rec_last  out  1  final word of the burst
cur_rec  out  clog2(NUM_RECORDS)  record index being scanned
scan_wrap  out  1  1-cycle pulse when cur_rec wraps to 0
busy  out  1  FSM state is not IDLE

Behaviour:
- Reset (async assert): state=IDLE; cur_rec=0. All outputs 0, including ram_addr, ram_wren and wr_gnt.
- Record base address: base = cur_rec*WORDS_PER_REC. The valid bit is word 0 bit 0.
- States: IDLE, READ_HDR, CHECK, STREAM, DRAIN, WAIT_DONE, NEXT.
- IDLE: go to READ_HDR when enable && pb_ready; otherwise hold.
- READ_HDR (t0): drive ram_addr=base. If wr_req is high, the writer owns the port and the state holds.
- CHECK (t1): ram_rdata holds word 0. Drive ram_addr=base+1 speculatively.
  - Bit0=1: register word 0 to the output; go to STREAM.
  - Bit0=0: go to NEXT; no rec_valid is produced.
- STREAM: issue base+2 .. base+WORDS_PER_REC-1, one per cycle (t2..t7 at default); then go to DRAIN.
- DRAIN (t8): no new address; capture the last word; go to WAIT_DONE.
- Output timing: word k appears on rec_data with rec_valid=1 and rec_word=k at t2+k (t2..t9). There are no gaps. rec_last=1 only with word WORDS_PER_REC-1.
- WAIT_DONE: hold until pb_done, then go to NEXT. A pb_done pulse in any other state is ignored.
- NEXT: cur_rec increments modulo NUM_RECORDS. On the wrap to 0, scan_wrap=1 for that cycle. Then go to IDLE.
- Arbitration:
  - Locked states: CHECK, STREAM, DRAIN. In these, wr_gnt=0 and the burst is atomic. Worst-case writer wait is 8 cycles at default sizes.
  - In every other state, wr_gnt=wr_req. When granted: ram_addr=wr_addr, ram_wdata=wr_data, ram_wren=1.
  - When not granted: ram_wren=0 and ram_wdata=0.
- Idle port: when no read is issued and no write is granted, ram_addr holds its last value.
- enable deassertion mid-burst does not abort the burst; it takes effect in IDLE.
- Reset mid-burst: outputs clear immediately; scanning restarts at record 0.
- Widths: address arithmetic is unsigned ADDR_W. Overflow is impossible given the parameter constraint.

Test Plan:
- Reset: assert reset=0 during activity -> all outputs 0, cur_rec=0, busy=0; after release, with enable=0, stays IDLE.
- Valid record 0 (word0=0x00000001, words1..7=0x11111111..0x77777777), enable=pb_ready=1 -> ram_addr 0..7 on t0..t7; rec_valid t2..t9 with rec_word 0..7 and matching data; rec_last only at t9; pb_done at t12 -> cur_rec=1.
- All records invalid (word0=0) -> rec_valid never asserts; each record takes 4 cycles; scan_wrap pulses once per 128 cycles as cur_rec goes 31->0.
- Writer contention, case 1: wr_req with wr_addr=0x010 and data 0xDEADBEEF during READ_HDR -> wr_gnt=1, ram_wren=1, ram_addr=0x010; READ_HDR repeats afterwards.
- Writer contention, case 2: wr_req raised at t3 -> wr_gnt=0 through t8, grant at t9, burst data unchanged.
- Async reset at t5 of a burst -> rec_valid drops immediately, no rec_last; after release, rescan starts with ram_addr=0.
